// File: rtl/regfile_pkg.sv
// Constants and state type shared by the register-file writer, the regfile
// and the readback checker.
package regfile_pkg;

   localparam int RF_DEPTH  = 32;
   localparam int RF_WIDTH  = 32;
   localparam int RF_ADDR_W = 5;

   localparam logic [RF_WIDTH-1:0] RF_BASE_LO = 32'hFFFF000F;
   localparam logic [RF_WIDTH-1:0] RF_BASE_HI = 32'h0000FFF0;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      CHECK,
      PACE,
      DONE
   } rb_state_t;

endpackage

// File: rtl/rf_check_lane.sv
// One read port's expected-word generator and comparator: the entry at
// offset index within its half should hold BASE + DIR*index (mod 2^WIDTH).
module rf_check_lane #(
   parameter int                WIDTH  = 32,
   parameter int                ADDR_W = 5,
   parameter logic [WIDTH-1:0]  BASE   = '0,
   parameter int                DIR    = 1
) (
   input  logic [ADDR_W-1:0] index,
   input  logic [WIDTH-1:0]  data,
   output logic              mismatch
);

   logic [WIDTH-1:0] expected;

   generate
      if (DIR >= 0) begin : g_up
         assign expected = BASE + WIDTH'(index);
      end else begin : g_down
         assign expected = BASE - WIDTH'(index);
      end
   endgenerate

   assign mismatch = (data != expected);

endmodule

// File: rtl/regfile_readback_checker.sv
// Sweeps both regfile read ports one address pair per step and counts
// entries that differ from the writer's pattern.
module regfile_readback_checker
   import regfile_pkg::*;
#(
   parameter int                  DEPTH   = RF_DEPTH,
   parameter int                  WIDTH   = RF_WIDTH,
   parameter logic [WIDTH-1:0]    BASE_LO = RF_BASE_LO,
   parameter logic [WIDTH-1:0]    BASE_HI = RF_BASE_HI
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       tick,
   input  logic [WIDTH-1:0]           rd_data1,
   input  logic [WIDTH-1:0]           rd_data2,
   output logic [$clog2(DEPTH)-1:0]   rd_s1,
   output logic [$clog2(DEPTH)-1:0]   rd_s2,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(DEPTH):0]     err_count,
   output logic                       err_flag,
   output logic [$clog2(DEPTH)-1:0]   first_err_addr,
   output logic [WIDTH-1:0]           disp_data
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int ERR_W  = ADDR_W + 1;
   localparam int HALF   = DEPTH / 2;
   localparam logic [ADDR_W-1:0] HALF_A = ADDR_W'(HALF);
   localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(HALF - 1);

   rb_state_t         state;
   rb_state_t         next_state;
   logic [ADDR_W-1:0] index;
   logic              mis1;
   logic              mis2;

   rf_check_lane #(
      .WIDTH (WIDTH),
      .ADDR_W(ADDR_W),
      .BASE  (BASE_LO),
      .DIR   (1)
   ) u_lane1 (
      .index   (index),
      .data    (rd_data1),
      .mismatch(mis1)
   );

   rf_check_lane #(
      .WIDTH (WIDTH),
      .ADDR_W(ADDR_W),
      .BASE  (BASE_HI),
      .DIR   (-1)
   ) u_lane2 (
      .index   (index),
      .data    (rd_data2),
      .mismatch(mis2)
   );

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = ISSUE;
         ISSUE:   next_state = CHECK;
         CHECK:   next_state = (index == LAST) ? DONE : PACE;
         PACE:    if (tick) next_state = ISSUE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Selects are loaded on entry to ISSUE so the regfile sees them a full
   // cycle before CHECK; this covers both combinational and registered reads.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         index          <= '0;
         rd_s1          <= '0;
         rd_s2          <= '0;
         err_count      <= '0;
         first_err_addr <= '0;
         disp_data      <= '0;
      end else begin
         state <= next_state;
         if (state == IDLE && next_state == ISSUE) begin
            index          <= '0;
            rd_s1          <= '0;
            rd_s2          <= HALF_A;
            err_count      <= '0;
            first_err_addr <= '0;
         end
         if (state == PACE && next_state == ISSUE) begin
            rd_s1 <= index;
            rd_s2 <= index + HALF_A;
         end
         if (state == CHECK) begin
            err_count <= err_count + ERR_W'(mis1) + ERR_W'(mis2);
            // A zero count means no mismatch yet this sweep; port 1 wins ties.
            if (err_count == '0) begin
               if (mis1)
                  first_err_addr <= index;
               else if (mis2)
                  first_err_addr <= index + HALF_A;
            end
            disp_data <= rd_data1;
            if (index != LAST)
               index <= index + 1'b1;
         end
      end
   end

   assign busy     = (state != IDLE);
   assign done     = (state == DONE);
   assign err_flag = (err_count != '0);

endmodule

// File: tb/tb_regfile_readback_checker.sv
// Bench for regfile_readback_checker: a combinational regfile model feeds the
// read ports and each sweep is compared against a pattern-level reference.
module tb_regfile_readback_checker;
   import regfile_pkg::*;

   localparam int HALF = RF_DEPTH / 2;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 start;
   logic                 tick;
   logic [RF_WIDTH-1:0]  rd_data1;
   logic [RF_WIDTH-1:0]  rd_data2;
   logic [RF_ADDR_W-1:0] rd_s1;
   logic [RF_ADDR_W-1:0] rd_s2;
   logic                 busy;
   logic                 done;
   logic [RF_ADDR_W:0]   err_count;
   logic                 err_flag;
   logic [RF_ADDR_W-1:0] first_err_addr;
   logic [RF_WIDTH-1:0]  disp_data;

   logic [RF_WIDTH-1:0]  mem [RF_DEPTH];

   int errors = 0;
   int checks = 0;
   int tick_period = 1;
   int tick_cnt = 0;
   int busy_low;
   int sel_bad;
   int sel_changes;

   typedef struct {
      int                  fa;
      logic [RF_WIDTH-1:0] va;
      int                  fb;
      logic [RF_WIDTH-1:0] vb;
      int                  exp_err;
      int                  exp_first;
      logic [RF_WIDTH-1:0] exp_disp;
   } vec_t;

   vec_t vecs [6];

   regfile_readback_checker dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .tick          (tick),
      .rd_data1      (rd_data1),
      .rd_data2      (rd_data2),
      .rd_s1         (rd_s1),
      .rd_s2         (rd_s2),
      .busy          (busy),
      .done          (done),
      .err_count     (err_count),
      .err_flag      (err_flag),
      .first_err_addr(first_err_addr),
      .disp_data     (disp_data)
   );

   always #5 clk = ~clk;

   assign rd_data1 = mem[rd_s1];
   assign rd_data2 = mem[rd_s2];

   // Tick changes shortly after each rising edge so it is stable at both
   // the negedge sample point and the next active edge.
   initial begin
      tick = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         tick_cnt++;
         tick = (tick_period <= 1) ? 1'b1 : ((tick_cnt % tick_period) == 0);
      end
   end

   function automatic logic [RF_WIDTH-1:0] pattern(input int a);
      if (a < HALF) return RF_BASE_LO + RF_WIDTH'(a);
      return RF_BASE_HI - RF_WIDTH'(a - HALF);
   endfunction

   // Step k reads address k then k+HALF; count bad entries in that order.
   function automatic void model(output int cnt, output int first);
      int seen;
      cnt = 0;
      first = 0;
      seen = 0;
      for (int k = 0; k < HALF; k++) begin
         for (int p = 0; p < 2; p++) begin
            int a;
            a = k + p * HALF;
            if (mem[a] != pattern(a)) begin
               cnt++;
               if (seen == 0) first = a;
               seen = 1;
            end
         end
      end
   endfunction

   task automatic loadClean();
      for (int a = 0; a < RF_DEPTH; a++) mem[a] = pattern(a);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Pulse start, then watch every cycle until done or the budget runs out.
   task automatic applyStimulus(output int done_cycle);
      logic [RF_ADDR_W-1:0] prev_s1;
      logic                 prev_tick;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      done_cycle = -1;
      busy_low = 0;
      sel_bad = 0;
      sel_changes = 0;
      prev_s1 = '0;
      prev_tick = 1'b0;
      for (int cyc = 1; cyc <= 2000; cyc++) begin
         @(negedge clk);
         if (!busy) busy_low++;
         if (cyc > 1 && rd_s1 != prev_s1) begin
            sel_changes++;
            if (!prev_tick || rd_s1 != RF_ADDR_W'(prev_s1 + 1'b1)) sel_bad++;
         end
         prev_s1 = rd_s1;
         prev_tick = tick;
         if (done) begin
            done_cycle = cyc;
            break;
         end
      end
      checkOutput("done_seen", 32'(done_cycle >= 0), 32'd1);
   endtask

   task automatic checkSweep(input int done_cycle, input int exp_err,
                             input int exp_first, input logic [31:0] exp_disp,
                             input int exp_cycle);
      if (exp_cycle > 0) checkOutput("done_cycle", 32'(done_cycle), 32'(exp_cycle));
      checkOutput("err_count", 32'(err_count), 32'(exp_err));
      checkOutput("err_flag", 32'(err_flag), 32'(exp_err != 0));
      checkOutput("first_err_addr", 32'(first_err_addr), 32'(exp_first));
      checkOutput("disp_data", disp_data, exp_disp);
      checkOutput("busy_in_sweep", 32'(busy_low), 32'd0);
      checkOutput("sel_order", 32'(sel_bad), 32'd0);
      checkOutput("sel_changes", 32'(sel_changes), 32'(HALF - 1));
      @(negedge clk);
      checkOutput("done_one_cycle", 32'(done), 32'd0);
      checkOutput("busy_after", 32'(busy), 32'd0);
      checkOutput("err_hold", 32'(err_count), 32'(exp_err));
   endtask

   initial begin
      int dc;
      int m_err;
      int m_first;
      int done_seen;
      int last_done;
      int cyc;

      vecs[0] = '{-1, 32'h0, -1, 32'h0, 0, 0, 32'hFFFF001E};
      vecs[1] = '{5, 32'h0, 20, 32'h0, 2, 20, 32'hFFFF001E};
      vecs[2] = '{3, 32'hDEAD, 19, 32'h0, 2, 3, 32'hFFFF001E};
      vecs[3] = '{15, 32'h0, -1, 32'h0, 1, 15, 32'h0};
      vecs[4] = '{31, 32'h1, -1, 32'h0, 1, 31, 32'hFFFF001E};
      vecs[5] = '{8, 32'h0, 16, 32'h0, 2, 16, 32'hFFFF001E};

      loadClean();
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_rd_s1", 32'(rd_s1), 32'd0);
      checkOutput("rst_rd_s2", 32'(rd_s2), 32'd0);
      checkOutput("rst_err_count", 32'(err_count), 32'd0);
      checkOutput("rst_disp", disp_data, 32'd0);

      // Fixed fault patterns, including the step-order and tie cases.
      for (int i = 0; i < 6; i++) begin
         loadClean();
         if (vecs[i].fa >= 0) mem[vecs[i].fa] = vecs[i].va;
         if (vecs[i].fb >= 0) mem[vecs[i].fb] = vecs[i].vb;
         applyStimulus(dc);
         checkSweep(dc, vecs[i].exp_err, vecs[i].exp_first, vecs[i].exp_disp, 3 * HALF);
      end

      // Random faults against the pattern-level model.
      for (int r = 0; r < 6; r++) begin
         int n;
         loadClean();
         n = $urandom_range(0, 3);
         for (int f = 0; f < n; f++) begin
            int a;
            a = $urandom_range(0, RF_DEPTH - 1);
            mem[a] = pattern(a) ^ ($urandom() | 32'd1);
         end
         model(m_err, m_first);
         applyStimulus(dc);
         checkSweep(dc, m_err, m_first, mem[HALF - 1], 3 * HALF);
      end

      // Slow pacing: selects may only move after a tick seen in PACE.
      loadClean();
      tick_period = 4;
      applyStimulus(dc);
      checkOutput("pace_slower", 32'(dc > 3 * HALF), 32'd1);
      checkSweep(dc, 0, 0, 32'hFFFF001E, 0);
      tick_period = 1;

      // Reset mid-sweep clears everything; a fresh sweep then runs clean.
      loadClean();
      mem[2] = 32'h0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("pre_reset_err", 32'(err_count), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      checkOutput("mid_rst_rd_s1", 32'(rd_s1), 32'd0);
      checkOutput("mid_rst_err", 32'(err_count), 32'd0);
      checkOutput("mid_rst_first", 32'(first_err_addr), 32'd0);
      loadClean();
      applyStimulus(dc);
      checkSweep(dc, 0, 0, 32'hFFFF001E, 3 * HALF);

      // Reset and start together: reset wins.
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      checkOutput("rst_beats_start", 32'(busy), 32'd0);

      // Start held high: back-to-back sweeps, errors cleared at relaunch.
      loadClean();
      mem[7] = 32'h0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      done_seen = 0;
      last_done = 0;
      cyc = 0;
      while (done_seen < 3 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            if (done_seen > 0) checkOutput("held_interval", 32'(cyc - last_done), 32'd49);
            checkOutput("held_err", 32'(err_count), (done_seen == 1) ? 32'd0 : 32'd1);
            done_seen++;
            last_done = cyc;
            if (done_seen == 1) loadClean();
            if (done_seen == 2) mem[7] = 32'h0;
         end
      end
      start = 1'b0;
      checkOutput("held_dones", 32'(done_seen), 32'd3);
      repeat (60) @(negedge clk);
      checkOutput("held_idle", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
